// File: rtl/step_ctrl_pkg.sv
// Shared encodings for the push-button step controller: FSM states, button
// patterns and a counter-width helper.
package step_ctrl_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DEB     = 3'd1;
  localparam logic [2:0] ST_PRESSED = 3'd2;
  localparam logic [2:0] ST_REPEAT  = 3'd3;
  localparam logic [2:0] ST_REL     = 3'd4;

  // Pattern bit 1 is the up button, bit 0 the down button.
  localparam logic [1:0] PAT_NONE = 2'b00;
  localparam logic [1:0] PAT_DN   = 2'b01;
  localparam logic [1:0] PAT_UP   = 2'b10;
  localparam logic [1:0] PAT_BOTH = 2'b11;

  function automatic int cnt_width(input int target);
    return (target > 1) ? $clog2(target) : 1;
  endfunction

endpackage

// File: rtl/step_button_ctrl_btn_sync.sv
// Two-flop synchroniser for one raw asynchronous button input.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b0;
      q        <= 1'b0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/step_button_ctrl.sv
// Debounces and arbitrates two push-buttons into exclusive one-cycle up/down
// step strobes. Define AUTOREPEAT_EN to build hold-to-repeat.
module step_button_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DEB_CNT    = 500000,
  parameter int RPT_DELAY  = 25000000,
  parameter int RPT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn_up,
  input  logic btn_dn,
  output logic step_up,
  output logic step_dn,
  output logic held
);

  localparam int DW = cnt_width(DEB_CNT);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);

  logic [1:0] raw;
  logic [1:0] s;

  assign raw = {btn_up, btn_dn};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    btn_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (raw[gi]),
      .q   (s[gi])
    );
  end

  logic [2:0]    state_reg, state_next;
  logic [1:0]    pat_reg, pat_next;
  logic [DW-1:0] deb_cnt_reg, deb_cnt_next;
  logic [DW-1:0] deb_cnt_inc;
  logic          fire;

  assign deb_cnt_inc = (deb_cnt_reg == '1) ? deb_cnt_reg : deb_cnt_reg + 1'b1;

`ifdef AUTOREPEAT_EN
  localparam int RW = cnt_width((RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD);
  localparam logic [RW-1:0] RPT_DELAY_LAST  = RW'(RPT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PERIOD_LAST = RW'(RPT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt_reg, rpt_cnt_next;
  logic [RW-1:0] rpt_cnt_inc;

  assign rpt_cnt_inc = (rpt_cnt_reg == '1) ? rpt_cnt_reg : rpt_cnt_reg + 1'b1;
`endif

  always_comb begin
    state_next   = state_reg;
    pat_next     = pat_reg;
    deb_cnt_next = deb_cnt_reg;
    fire         = 1'b0;
`ifdef AUTOREPEAT_EN
    rpt_cnt_next = rpt_cnt_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (s != PAT_NONE) begin
          state_next   = ST_DEB;
          pat_next     = s;
          deb_cnt_next = '0;
        end
      end
      ST_DEB: begin
        if (s != pat_reg) begin
          pat_next     = s;
          deb_cnt_next = '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          deb_cnt_next = '0;
          case (pat_reg)
            PAT_UP, PAT_DN: begin
              fire       = 1'b1;
              state_next = ST_PRESSED;
`ifdef AUTOREPEAT_EN
              rpt_cnt_next = '0;
`endif
            end
            PAT_BOTH: state_next = ST_REL;
            default:  state_next = ST_IDLE;
          endcase
        end else begin
          deb_cnt_next = deb_cnt_inc;
        end
      end
      ST_PRESSED: begin
        if (s != pat_reg) begin
          state_next   = ST_REL;
          deb_cnt_next = '0;
`ifdef AUTOREPEAT_EN
        end else if (rpt_cnt_reg == RPT_DELAY_LAST) begin
          fire         = 1'b1;
          state_next   = ST_REPEAT;
          rpt_cnt_next = '0;
        end else begin
          rpt_cnt_next = rpt_cnt_inc;
`endif
        end
      end
`ifdef AUTOREPEAT_EN
      ST_REPEAT: begin
        if (s != pat_reg) begin
          state_next   = ST_REL;
          deb_cnt_next = '0;
        end else if (rpt_cnt_reg == RPT_PERIOD_LAST) begin
          fire         = 1'b1;
          rpt_cnt_next = '0;
        end else begin
          rpt_cnt_next = rpt_cnt_inc;
        end
      end
`endif
      ST_REL: begin
        // Both buttons must read released for a full debounce window.
        if (s != PAT_NONE) begin
          deb_cnt_next = '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next   = ST_IDLE;
          deb_cnt_next = '0;
        end else begin
          deb_cnt_next = deb_cnt_inc;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (!en) begin
      state_next = ST_IDLE;
      fire       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      pat_reg     <= PAT_NONE;
      deb_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pat_reg     <= pat_next;
      deb_cnt_reg <= deb_cnt_next;
    end
  end

`ifdef AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt_reg <= '0;
    end else begin
      rpt_cnt_reg <= rpt_cnt_next;
    end
  end
`endif

  // Strobe direction comes from the latched pattern, so at most one can fire.
  assign step_up = fire && (pat_reg == PAT_UP);
  assign step_dn = fire && (pat_reg == PAT_DN);
  assign held    = (state_reg == ST_PRESSED) || (state_reg == ST_REPEAT);

endmodule

// File: tb/tb_step_button_ctrl.sv
// Scoreboard bench for step_button_ctrl: expected strobes are queued with the
// stimulus and matched against the strobes the DUT emits.
module tb_step_button_ctrl;
  import step_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst, en, btn_up, btn_dn;
  logic step_up, step_dn, held;

  typedef struct {
    int   cyc;
    logic up;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  step_button_ctrl #(
    .DEB_CNT    (4),
    .RPT_DELAY  (20),
    .RPT_PERIOD (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .btn_up  (btn_up),
    .btn_dn  (btn_dn),
    .step_up (step_up),
    .step_dn (step_dn),
    .held    (held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (step_up && step_dn) begin
      total++;
      bad++;
      $display("FAIL both_strobes cyc=%0d got up=1 dn=1 required at most one", cyc);
    end else if (step_up || step_dn) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe cyc=%0d got up=%0b dn=%0b required none", cyc, step_up, step_dn);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc !== cyc || e.up !== step_up) begin
          bad++;
          $display("FAIL strobe_match got cyc=%0d up=%0b required cyc=%0d up=%0b", cyc, step_up, e.cyc, e.up);
        end else begin
          $display("strobe cyc=%0d dir=%s ok", cyc, step_up ? "up" : "dn");
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic up);
    exp_t e;
    e.cyc = c;
    e.up  = up;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; btn_up = 1'b0; btn_dn = 1'b0;
    repeat (3) begin
      tick();
      total++;
      if ({step_up, step_dn, held} !== 3'b000 || dut.state_reg !== ST_IDLE) begin
        bad++;
        $display("FAIL reset_state got outs=%b state=%0d required outs=000 state=%0d",
                 {step_up, step_dn, held}, dut.state_reg, ST_IDLE);
      end
    end
    rst = 1'b0;
    $display("reset released cyc=%0d", cyc);
  endtask

  task automatic test_single_up();
    int n;
    tick();
    n = cyc;
    btn_up = 1'b1;
    push(n + 6, 1'b1);
    repeat (8) tick();
    total++;
    if (held !== 1'b1) begin
      bad++;
      $display("FAIL single_up_held got %b required 1", held);
    end
    repeat (2) tick();
    btn_up = 1'b0;
    repeat (12) tick();
    total++;
    if (held !== 1'b0 || dut.state_reg !== ST_IDLE || exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_up_end got held=%b state=%0d pending=%0d required held=0 state=%0d pending=0",
               held, dut.state_reg, exp_q.size(), ST_IDLE);
      exp_q.delete();
    end
  endtask

  task automatic test_bounce();
    btn_dn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat (2) tick();
      btn_dn = ~btn_dn;
      total++;
      if (held !== 1'b0) begin
        bad++;
        $display("FAIL bounce_held step=%0d got %b required 0", i, held);
      end
    end
    btn_dn = 1'b0;
    repeat (12) tick();
    total++;
    if (dut.state_reg !== ST_IDLE || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bounce_idle got state=%0d pending=%0d required state=%0d pending=0",
               dut.state_reg, exp_q.size(), ST_IDLE);
      exp_q.delete();
    end
  endtask

  task automatic test_conflict();
    btn_up = 1'b1;
    btn_dn = 1'b1;
    repeat (10) tick();
    total++;
    if (held !== 1'b0 || dut.state_reg !== ST_REL) begin
      bad++;
      $display("FAIL conflict_rel got held=%b state=%0d required held=0 state=%0d", held, dut.state_reg, ST_REL);
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (5) tick();
    total++;
    if (dut.state_reg !== ST_REL) begin
      bad++;
      $display("FAIL conflict_early_idle got state=%0d required %0d", dut.state_reg, ST_REL);
    end
    tick();
    total++;
    if (dut.state_reg !== ST_IDLE) begin
      bad++;
      $display("FAIL conflict_idle got state=%0d required %0d", dut.state_reg, ST_IDLE);
    end
  endtask

  task automatic test_dn_then_up();
    int n;
    tick();
    n = cyc;
    btn_dn = 1'b1;
    push(n + 6, 1'b0);
    repeat (7) tick();
    btn_up = 1'b1;
    repeat (8) tick();
    total++;
    if (held !== 1'b0) begin
      bad++;
      $display("FAIL dn_then_up_held got %b required 0", held);
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (12) tick();
    total++;
    if (dut.state_reg !== ST_IDLE || exp_q.size() != 0) begin
      bad++;
      $display("FAIL dn_then_up_end got state=%0d pending=%0d required state=%0d pending=0",
               dut.state_reg, exp_q.size(), ST_IDLE);
      exp_q.delete();
    end
  endtask

  task automatic test_enable();
    int m;
    tick();
    en = 1'b0;
    btn_up = 1'b1;
    repeat (10) tick();
    total++;
    if (held !== 1'b0 || dut.state_reg !== ST_IDLE) begin
      bad++;
      $display("FAIL enable_off got held=%b state=%0d required held=0 state=%0d", held, dut.state_reg, ST_IDLE);
    end
    m = cyc;
    en = 1'b1;
    push(m + 4, 1'b1);
    repeat (8) tick();
    total++;
    if (held !== 1'b1) begin
      bad++;
      $display("FAIL enable_on_held got %b required 1", held);
    end
    btn_up = 1'b0;
    repeat (12) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL enable_missing got pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_press();
    int n, r;
    tick();
    n = cyc;
    btn_up = 1'b1;
    push(n + 6, 1'b1);
    repeat (8) tick();
    r = cyc;
    rst = 1'b1;
    tick();
    total++;
    if ({step_up, step_dn, held} !== 3'b000 || dut.state_reg !== ST_IDLE) begin
      bad++;
      $display("FAIL mid_reset got outs=%b state=%0d required outs=000 state=%0d",
               {step_up, step_dn, held}, dut.state_reg, ST_IDLE);
    end
    rst = 1'b0;
    push(r + 7, 1'b1);
    repeat (9) tick();
    btn_up = 1'b0;
    repeat (12) tick();
    total++;
    if (exp_q.size() != 0 || dut.state_reg !== ST_IDLE) begin
      bad++;
      $display("FAIL mid_reset_end got pending=%0d state=%0d required pending=0 state=%0d",
               exp_q.size(), dut.state_reg, ST_IDLE);
      exp_q.delete();
    end
  endtask

`ifdef AUTOREPEAT_EN
  task automatic test_autorepeat();
    int n;
    tick();
    n = cyc;
    btn_up = 1'b1;
    push(n + 6, 1'b1);
    for (int t = n + 26; t <= n + 61; t += 8) push(t, 1'b1);
    repeat (60) tick();
    btn_up = 1'b0;
    repeat (14) tick();
    total++;
    if (exp_q.size() != 0 || dut.state_reg !== ST_IDLE) begin
      bad++;
      $display("FAIL autorepeat_end got pending=%0d state=%0d required pending=0 state=%0d",
               exp_q.size(), dut.state_reg, ST_IDLE);
      exp_q.delete();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_up();
    test_bounce();
    test_conflict();
    test_dn_then_up();
    test_enable();
    test_reset_mid_press();
`ifdef AUTOREPEAT_EN
    test_autorepeat();
`endif
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
